// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: requester <-> bit-serial adder bundle.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed-overflow flag.
//
// Handshake: start is a request pulse sampled on the rising clock edge. It is
// accepted only in IDLE or DONE; while busy=1 it is ignored. Completion is a
// single-cycle done pulse; sum/carry (and ovf) are valid in that cycle and are
// held until the next completion. state is a debug view of the controller FSM.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif
  logic [1:0]       state;

`ifdef SERIAL_ADD_OVF_EN
  modport master (output start, a, b, input busy, done, sum, carry, ovf, state);
  modport slave  (input start, a, b, output busy, done, sum, carry, ovf, state);
`else
  modport master (output start, a, b, input busy, done, sum, carry, state);
  modport slave  (input start, a, b, output busy, done, sum, carry, state);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller. Two half adders form one
// full-adder slice that is stepped across WIDTH cycles, LSB first.
// Optional feature macro: SERIAL_ADD_OVF_EN (registered signed-overflow output).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             c_reg;
  logic [CW-1:0]    cnt;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_r;
`endif

  // Half adder ha0: current operand bits.
  logic ha0_sum, ha0_carry;
  assign ha0_sum   = a_sh[0] ^ b_sh[0];
  assign ha0_carry = a_sh[0] & b_sh[0];

  // Half adder ha1: ha0 result plus the stored carry.
  logic ha1_sum, ha1_carry;
  assign ha1_sum   = ha0_sum ^ c_reg;
  assign ha1_carry = ha0_sum & c_reg;

  logic             c_next;
  logic [WIDTH-1:0] s_next;
  assign c_next = ha0_carry | ha1_carry;
  // New bit enters at the MSB so after WIDTH shifts bit 0 lands at index 0.
  assign s_next = (s_sh >> 1) | (WIDTH'(ha1_sum) << (WIDTH - 1));

  // Controller FSM with capture, bit sequencing and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      c_reg   <= 1'b0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      carry_r <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            c_reg  <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_next;
          c_reg <= c_next;
          if (cnt == LAST) begin
            // Last bit: publish the result on the same edge as entering DONE.
            state   <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            sum_r   <= s_next;
            carry_r <= c_next;
`ifdef SERIAL_ADD_OVF_EN
            // c_reg holds the carry into the MSB during this cycle.
            ovf_r   <= c_reg ^ c_next;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            c_reg  <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.sum   = sum_r;
  assign bus.carry = carry_r;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf   = ovf_r;
`endif
  assign bus.state = state;

endmodule
